// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// States, owner tags and the "no write" byte-enable constant.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [3:0] WR_NONE = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between fetch and data stages; data wins ties.
// Optional fetch starvation guard: MEM_PORT_ARBITER_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t      state, nxt_state;
    owner_t      owner, nxt_owner;
    logic [2:0]  cnt, nxt_cnt;
    logic        nxt_mem_en;
    logic [31:0] nxt_mem_addr;
    logic [3:0]  nxt_mem_wr;
    logic [31:0] nxt_mem_wdata;
    logic [31:0] nxt_if_rdata;
    logic [31:0] nxt_d_rdata;
    logic        nxt_if_ack;
    logic        nxt_d_ack;
    logic        pick_d;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    localparam logic [7:0] SMAX = 8'(STARVE_MAX);

    logic [7:0] starve_cnt, nxt_starve_cnt;
    logic       force_if;

    // Fetch is forced once data has won SMAX grants in a row over it.
    always_comb begin
        force_if = if_req && d_req && (starve_cnt == SMAX);
        pick_d   = d_req && !force_if;
    end
`else
    logic unused_starve_max;

    assign unused_starve_max = |STARVE_MAX;

    // Fixed priority: data always wins.
    always_comb begin
        pick_d = d_req;
    end
`endif

    assign busy = (state != IDLE);

    // Next-state and next-register values for the access sequencer.
    always_comb begin
        nxt_state     = state;
        nxt_owner     = owner;
        nxt_cnt       = cnt;
        nxt_mem_en    = mem_en;
        nxt_mem_addr  = mem_addr;
        nxt_mem_wr    = mem_wr;
        nxt_mem_wdata = mem_wdata;
        nxt_if_rdata  = if_rdata;
        nxt_d_rdata   = d_rdata;
        nxt_if_ack    = if_ack;
        nxt_d_ack     = d_ack;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
        nxt_starve_cnt = starve_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    nxt_state  = WAIT;
                    nxt_mem_en = 1'b1;
                    nxt_cnt    = LAT;
                    if (pick_d) begin
                        nxt_owner     = OWN_D;
                        nxt_mem_addr  = d_addr;
                        nxt_mem_wr    = d_wr;
                        nxt_mem_wdata = d_wdata;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
                        nxt_starve_cnt = if_req ? starve_cnt + 8'd1 : 8'd0;
`endif
                    end else begin
                        nxt_owner    = OWN_IF;
                        nxt_mem_addr = if_addr;
                        nxt_mem_wr   = WR_NONE;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
                        nxt_starve_cnt = 8'd0;
`endif
                    end
                end
            end
            WAIT: begin
                nxt_mem_en = 1'b0;
                if (cnt == 3'd0) begin
                    nxt_state = DONE;
                    if (owner == OWN_D) begin
                        nxt_d_ack = 1'b1;
                        if (mem_wr == WR_NONE) begin
                            nxt_d_rdata = mem_rdata;
                        end
                    end else begin
                        nxt_if_ack   = 1'b1;
                        nxt_if_rdata = mem_rdata;
                    end
                end else begin
                    nxt_cnt = cnt - 3'd1;
                end
            end
            DONE: begin
                nxt_if_ack = 1'b0;
                nxt_d_ack  = 1'b0;
                nxt_state  = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Register bank; reset abandons any in-flight access without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            cnt       <= 3'd0;
            mem_en    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wr    <= WR_NONE;
            mem_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
            starve_cnt <= 8'd0;
`endif
        end else begin
            state     <= nxt_state;
            owner     <= nxt_owner;
            cnt       <= nxt_cnt;
            mem_en    <= nxt_mem_en;
            mem_addr  <= nxt_mem_addr;
            mem_wr    <= nxt_mem_wr;
            mem_wdata <= nxt_mem_wdata;
            if_rdata  <= nxt_if_rdata;
            d_rdata   <= nxt_d_rdata;
            if_ack    <= nxt_if_ack;
            d_ack     <= nxt_d_ack;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
            starve_cnt <= nxt_starve_cnt;
`endif
        end
    end

endmodule
